// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory; read data returns one cycle after accept.
// Optional lock feature: define MEM_ARB_LOCK_EN to add lock0/lock1 and exclusive ownership.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic              last_reg;
    logic              rpend_reg;
    logic              rsel_reg;
    logic [DATA_W-1:0] rbuf_reg;
    logic              allow0;
    logic              allow1;
    logic              cand0;
    logic              cand1;

`ifdef MEM_ARB_LOCK_EN
    logic locked_reg;
    logic owner_reg;
    logic acc_lock;

    // While locked, only the owner may be granted.
    assign allow0   = !locked_reg || !owner_reg;
    assign allow1   = !locked_reg || owner_reg;
    assign acc_lock = gnt0 ? lock0 : lock1;
`else
    assign allow0 = 1'b1;
    assign allow1 = 1'b1;
`endif

    assign cand0 = req0 && allow0;
    assign cand1 = req1 && allow1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (cand0 && cand1) begin
                // Tie goes to the port that was not granted last.
                gnt0 = last_reg;
                gnt1 = !last_reg;
            end else begin
                gnt0 = cand0;
                gnt1 = cand1;
            end
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt0) begin
            mem_we   = we0;
            mem_addr = addr0;
            mem_din  = wdata0;
        end else if (gnt1) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_din  = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg  <= 1'b1;
            rpend_reg <= 1'b0;
            rsel_reg  <= 1'b0;
            rbuf_reg  <= '0;
`ifdef MEM_ARB_LOCK_EN
            locked_reg <= 1'b0;
            owner_reg  <= 1'b0;
`endif
        end else if (gnt0 || gnt1) begin
            last_reg  <= gnt1;
            rpend_reg <= !mem_we;
            rsel_reg  <= gnt1;
            if (!mem_we) begin
                rbuf_reg <= mem_dout;
            end
`ifdef MEM_ARB_LOCK_EN
            // Any accepted owner transaction without lock releases it.
            locked_reg <= acc_lock;
            if (acc_lock) begin
                owner_reg <= gnt1;
            end
`endif
        end else begin
            rpend_reg <= 1'b0;
        end
    end

    // A response pending across a reset is suppressed, not emitted late.
    assign rvalid0 = !reset && rpend_reg && !rsel_reg;
    assign rvalid1 = !reset && rpend_reg && rsel_reg;
    assign rdata0  = reset ? '0 : rbuf_reg;
    assign rdata1  = reset ? '0 : rbuf_reg;

endmodule
